branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of flush cycles after redirect acceptance (legal 0..15).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, value of redir_pc out of reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous to clk and active-high.
REQ-005 SHALL have port ex_valid  input  1  EX-stage instruction valid.
REQ-006 SHALL have port ex_kind  input  2  control kind: 00 none, 01 conditional branch, 10 JAL, 11 JALR.
REQ-007 SHALL have ports ex_pc, ex_imm, ex_rs1  input  32 each  instruction PC, sign-extended immediate, rs1 operand.
REQ-008 SHALL have port take_branch  input  1  resolved direction from the branch comparator.
REQ-009 SHALL have port pred_taken  input  1  fetch-time prediction carried with the instruction.
REQ-010 SHALL have port redir_ready  input  1  fetch accepts the redirect.
REQ-011 SHALL have ports redir_valid (output, 1) and redir_pc (output, 32): the registered redirect request and its target.
REQ-012 SHALL have ports flush (output, 1), kill IF/ID contents, and ex_stall (output, 1), hold the EX stage.
REQ-013 SHALL have ports branch_cnt and mispredict_cnt, each output 32, performance counters.

Function
REQ-014 SHALL compute the target as ex_pc+ex_imm for kinds 01 and 10, and as (ex_rs1+ex_imm) with bit 0 cleared for kind 11; all sums are mod 2^32.
REQ-015 SHALL compute the fall-through as ex_pc+4 mod 2^32 (0xFFFF_FFFC gives 0x0000_0000).
REQ-016 SHALL flag a mispredict when, in IDLE, ex_valid=1, ex_kind!=00 and either take_branch!=pred_taken or ex_kind=11.
REQ-017 SHALL set the correct PC to the target if take_branch=1 and to the fall-through otherwise; no alignment check beyond clearing bit 0 for JALR.
REQ-018 SHALL implement FSM states IDLE, REDIR and FLUSH; the reset state is IDLE.
REQ-019 SHALL, in IDLE on a mispredict, latch the correct PC into redir_pc and enter REDIR; redir_valid then rises the next cycle (latency 1).
REQ-020 SHALL, in REDIR, hold redir_valid=1, keep redir_pc stable, drive ex_stall=1, and ignore all ex_* and take_branch inputs.
REQ-021 SHALL, in REDIR with redir_ready=1, complete the handshake: with FLUSH_CYCLES=0 go to IDLE, otherwise go to FLUSH with the counter loaded to FLUSH_CYCLES.
REQ-022 SHALL, in FLUSH, decrement the counter each cycle and go to IDLE on the cycle it reads 1, giving exactly FLUSH_CYCLES FLUSH cycles.
REQ-023 SHALL drive flush=1 whenever state!=IDLE, and redir_valid=1 only in REDIR.
REQ-024 SHALL ignore redir_ready when not in REDIR.
REQ-025 SHALL not raise a second redirect for an instruction in EX during REDIR or FLUSH; that instruction is squashed and not counted.
REQ-026 SHALL keep ex_stall=0 in IDLE and FLUSH.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, set state IDLE, redir_valid=0, redir_pc=RESET_PC, flush=0, ex_stall=0, the flush counter to 0, and both performance counters to 0.
REQ-028 SHALL let rst take priority over every simultaneous event, including a mispredict in the same cycle or a pending redirect in REDIR or FLUSH.

Configuration
REQ-029 SHALL, with macro BRANCH_STATS_EN defined, increment branch_cnt for each ex_valid && ex_kind!=00 seen in IDLE, and increment mispredict_cnt for each mispredict; both wrap mod 2^32.
REQ-030 SHALL, with BRANCH_STATS_EN undefined, keep the branch_cnt and mispredict_cnt ports but tie them to 0 with no counter logic.

Verification
REQ-031 SHALL cover: BEQ at ex_pc=0x100, ex_imm=0x40, take_branch=1, pred_taken=0 -> next cycle redir_valid=1 and redir_pc=0x140; ready on the 3rd cycle -> ex_stall high 2 cycles, flush high for REDIR plus 2 FLUSH cycles.
REQ-032 SHALL cover: take_branch=0, pred_taken=1, ex_pc=0xFFFF_FFFC -> redir_pc=0x0000_0000.
REQ-033 SHALL cover: JALR with ex_rs1=0x1001, ex_imm=0x4 and pred_taken=1 -> redir_pc=0x1004; a correctly predicted BNE produces no redirect and branch_cnt increments by 1 with stats enabled.
REQ-034 SHALL cover: rst asserted while in REDIR with redir_ready=0 -> next cycle redir_valid=0, flush=0 and redir_pc=RESET_PC.
REQ-035 SHALL cover: a mispredicting branch presented during FLUSH -> no new redirect and mispredict_cnt unchanged.
REQ-036 SHALL cover: FLUSH_CYCLES=0 with ready in the first REDIR cycle -> flush high exactly 1 cycle, then IDLE.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch/jump resolution: computes the correct PC, raises a registered redirect and
// sequences the REDIR/FLUSH recovery. Performance counters exist only with BRANCH_STATS_EN.
module branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [1:0]  ex_kind,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        take_branch,
  input  logic        pred_taken,
  input  logic        redir_ready,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic        flush,
  output logic        ex_stall,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REDIR = 2'b01,
    FLUSH = 2'b10
  } state_e;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_BR   = 2'b01;
  localparam logic [1:0] KIND_JAL  = 2'b10;
  localparam logic [1:0] KIND_JALR = 2'b11;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic        redir_valid_q, redir_valid_d;
  logic        flush_q, flush_d;
  logic        ex_stall_q, ex_stall_d;

  logic        is_ctrl;
  logic        mispredict;
  logic [31:0] jalr_sum;
  logic [31:0] target_pc;
  logic [31:0] fall_pc;
  logic [31:0] correct_pc;

  // Target, fall-through and mispredict detection for the instruction in EX
  always_comb begin
    is_ctrl  = ex_valid && (ex_kind != KIND_NONE);
    jalr_sum = ex_rs1 + ex_imm;
    fall_pc  = ex_pc + 32'd4;
    case (ex_kind)
      KIND_BR:   target_pc = ex_pc + ex_imm;
      KIND_JAL:  target_pc = ex_pc + ex_imm;
      KIND_JALR: target_pc = {jalr_sum[31:1], 1'b0};
      default:   target_pc = fall_pc;
    endcase
    if (take_branch) begin
      correct_pc = target_pc;
    end else begin
      correct_pc = fall_pc;
    end
    mispredict = is_ctrl && ((take_branch != pred_taken) || (ex_kind == KIND_JALR));
  end

  // Recovery FSM next-state; EX inputs only matter while IDLE
  always_comb begin
    state_d     = state_q;
    redir_pc_d  = redir_pc_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d    = REDIR;
          redir_pc_d = correct_pc;
        end else begin
          state_d = IDLE;
        end
      end
      REDIR: begin
        if (redir_ready && (FLUSH_CYCLES == 32'd0)) begin
          state_d     = IDLE;
          flush_cnt_d = 4'd0;
        end else if (redir_ready) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else begin
          state_d = REDIR;
        end
      end
      FLUSH: begin
        if (flush_cnt_q <= 4'd1) begin
          state_d     = IDLE;
          flush_cnt_d = 4'd0;
        end else begin
          state_d     = FLUSH;
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        flush_cnt_d = 4'd0;
      end
    endcase
    redir_valid_d = (state_d == REDIR);
    ex_stall_d    = (state_d == REDIR);
    flush_d       = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      redir_pc_q    <= RESET_PC;
      flush_cnt_q   <= 4'd0;
      redir_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      ex_stall_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      redir_pc_q    <= redir_pc_d;
      flush_cnt_q   <= flush_cnt_d;
      redir_valid_q <= redir_valid_d;
      flush_q       <= flush_d;
      ex_stall_q    <= ex_stall_d;
    end
  end

  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign flush       = flush_q;
  assign ex_stall    = ex_stall_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  // Counters only see instructions resolved in IDLE; squashed ones are not counted
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if ((state_q == IDLE) && is_ctrl) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end else begin
      branch_cnt_d = branch_cnt_q;
    end
    if ((state_q == IDLE) && mispredict) begin
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end else begin
      mispredict_cnt_d = mispredict_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q     <= 32'd0;
      mispredict_cnt_q <= 32'd0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
`else
  assign branch_cnt     = 32'd0;
  assign mispredict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: two instances (FLUSH_CYCLES=2 and 0) share stimulus,
// a cycle-level reference model pushes expectations, a negedge monitor pops and compares.
module tb_branch_resolve;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [1:0]  ex_kind;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic        take_branch, pred_taken, redir_ready;

  logic        rv2, fl2, st2;
  logic [31:0] pc2, bc2, mc2;
  logic        rv0, fl0, st0;
  logic [31:0] pc0, bc0, mc0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolve #(.FLUSH_CYCLES(2), .RESET_PC(RST_PC)) u_dut2 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .take_branch(take_branch), .pred_taken(pred_taken),
    .redir_ready(redir_ready), .redir_valid(rv2), .redir_pc(pc2), .flush(fl2),
    .ex_stall(st2), .branch_cnt(bc2), .mispredict_cnt(mc2));

  branch_resolve #(.FLUSH_CYCLES(0), .RESET_PC(RST_PC)) u_dut0 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .take_branch(take_branch), .pred_taken(pred_taken),
    .redir_ready(redir_ready), .redir_valid(rv0), .redir_pc(pc0), .flush(fl0),
    .ex_stall(st0), .branch_cnt(bc0), .mispredict_cnt(mc0));

  typedef struct {
    bit          redir;
    int          flush_left;
    logic [31:0] pc;
    logic [31:0] bc;
    logic [31:0] mc;
  } mdl_t;

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic        fl;
    logic        st;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  mdl_t m2 = '{redir: 1'b0, flush_left: 0, pc: 32'd0, bc: 32'd0, mc: 32'd0};
  mdl_t m0 = '{redir: 1'b0, flush_left: 0, pc: 32'd0, bc: 32'd0, mc: 32'd0};
  exp_t exp2_q[$];
  exp_t exp0_q[$];
  logic [31:0] rd2_q[$];
  logic [31:0] rd0_q[$];

  // Behaviour of one clock edge, described from the recovery rules rather than any encoding
  function automatic mdl_t mdl_step(mdl_t m, int fc);
    mdl_t n = m;
    logic [31:0] tgt;
    logic [31:0] good;
    bit is_br;
    bit wrong;
    if (rst) begin
      n.redir = 1'b0; n.flush_left = 0; n.pc = RST_PC; n.bc = 32'd0; n.mc = 32'd0;
    end else if (m.redir) begin
      if (redir_ready) begin
        n.redir = 1'b0;
        n.flush_left = fc;
      end
    end else if (m.flush_left > 0) begin
      n.flush_left = m.flush_left - 1;
    end else begin
      is_br = ex_valid && (ex_kind != 2'b00);
      wrong = is_br && ((take_branch != pred_taken) || (ex_kind == 2'b11));
      if (ex_kind == 2'b11) tgt = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
      else tgt = ex_pc + ex_imm;
      good = take_branch ? tgt : (ex_pc + 32'd4);
`ifdef BRANCH_STATS_EN
      if (is_br) n.bc = m.bc + 32'd1;
      if (wrong) n.mc = m.mc + 32'd1;
`endif
      if (wrong) begin
        n.redir = 1'b1;
        n.pc = good;
      end
    end
    return n;
  endfunction

  function automatic exp_t to_exp(mdl_t m);
    exp_t e;
    e.rv = m.redir;
    e.st = m.redir;
    e.fl = m.redir || (m.flush_left > 0);
    e.pc = m.pc;
    e.bc = m.bc;
    e.mc = m.mc;
    return e;
  endfunction

  task automatic step();
    mdl_t n2, n0;
    n2 = mdl_step(m2, 2);
    n0 = mdl_step(m0, 0);
    if (n2.redir && !m2.redir) rd2_q.push_back(n2.pc);
    if (n0.redir && !m0.redir) rd0_q.push_back(n0.pc);
    m2 = n2;
    m0 = n0;
    exp2_q.push_back(to_exp(m2));
    exp0_q.push_back(to_exp(m0));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1, input logic tb_,
                       input logic pt, input logic rdy, input logic r);
    ex_valid = v; ex_kind = k; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
    take_branch = tb_; pred_taken = pt; redir_ready = rdy; rst = r;
    step();
  endtask

  task automatic idle_cycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic rv, input logic [31:0] pc,
                     input logic fl, input logic st, input logic [31:0] bc, input logic [31:0] mc);
    chk({tag, ".redir_valid"}, {31'd0, rv}, {31'd0, e.rv});
    chk({tag, ".redir_pc"}, pc, e.pc);
    chk({tag, ".flush"}, {31'd0, fl}, {31'd0, e.fl});
    chk({tag, ".ex_stall"}, {31'd0, st}, {31'd0, e.st});
    chk({tag, ".branch_cnt"}, bc, e.bc);
    chk({tag, ".mispredict_cnt"}, mc, e.mc);
  endtask

  logic prev_rv2 = 1'b0;
  logic prev_rv0 = 1'b0;

  // Monitor: per-cycle scoreboard plus redirect target check on each new request
  always @(negedge clk) begin
    exp_t e;
    if (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      cmp("fc2", e, rv2, pc2, fl2, st2, bc2, mc2);
    end
    if (exp0_q.size() > 0) begin
      e = exp0_q.pop_front();
      cmp("fc0", e, rv0, pc0, fl0, st0, bc0, mc0);
    end
    if (rv2 === 1'b1 && prev_rv2 !== 1'b1) begin
      if (rd2_q.size() > 0) chk("fc2.redirect_target", pc2, rd2_q.pop_front());
      else chk("fc2.unexpected_redirect", {31'd0, rv2}, 32'd0);
    end
    if (rv0 === 1'b1 && prev_rv0 !== 1'b1) begin
      if (rd0_q.size() > 0) chk("fc0.redirect_target", pc0, rd0_q.pop_front());
      else chk("fc0.unexpected_redirect", {31'd0, rv0}, 32'd0);
    end
    prev_rv2 <= rv2;
    prev_rv0 <= rv0;
  end

  initial begin
    logic [31:0] r;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(2, 1'b1);

    // BEQ mispredict, ready arrives on the third cycle
    drive(1'b1, 2'b01, 32'h100, 32'h40, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(1, 1'b0);
    idle_cycles(1, 1'b1);
    idle_cycles(4, 1'b0);

    // Fall-through wraps to zero; ready in the first REDIR cycle
    drive(1'b1, 2'b01, 32'hFFFF_FFFC, 32'h20, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles(1, 1'b1);
    idle_cycles(4, 1'b0);

    // JALR clears bit 0, then a correctly predicted BNE
    drive(1'b1, 2'b11, 32'h400, 32'h4, 32'h1001, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(1, 1'b1);
    idle_cycles(3, 1'b0);
    drive(1'b1, 2'b01, 32'h500, 32'h10, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(2, 1'b0);

    // Reset while waiting in REDIR
    drive(1'b1, 2'b10, 32'h600, 32'h80, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(1, 1'b0);
    drive(1'b1, 2'b01, 32'h700, 32'h8, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_cycles(2, 1'b0);

    // Mispredicting branch arrives during FLUSH and must be squashed
    drive(1'b1, 2'b01, 32'h800, 32'h100, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(1, 1'b1);
    drive(1'b1, 2'b01, 32'h900, 32'h100, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 2'b11, 32'hA00, 32'h100, 32'h3, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_cycles(3, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      r = $urandom;
      drive(r[0] | r[1], r[3:2], $urandom & 32'hFFFF_FFFC, {{19{r[20]}}, r[20:8]}, $urandom,
            r[4], r[5], ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));
    end
    idle_cycles(6, 1'b1);
    @(negedge clk);
    #1;
    chk("pending_redirects_fc2", rd2_q.size(), 32'd0);
    chk("pending_redirects_fc0", rd0_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
